oled_cmd_sequencer: RTL

- Parametrised microcoded sequencer that replaces the fixed-format ROM-driven SSD1306 power-up engine.
- Fetches instruction words from an external synchronous ROM and drives the OLED control pins (vdd, vbat, res, dc).
- Pushes command/data bytes to the SPI master through a write/complete handshake.
- Supports timed delays and nested counted loops, with start/busy/done/error status for a host FSM.

---
 rtl/oled_cmd_sequencer_pkg.sv | 28 ++
 rtl/oled_cmd_sequencer_if.sv | 17 +
 rtl/oled_cmd_sequencer_loop_stack.sv | 56 +++++
 rtl/oled_cmd_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/oled_cmd_sequencer_pkg.sv
// Shared definitions for the OLED command sequencer: instruction fields,
// opcodes and FSM state encoding.
package oled_seq_pkg;

  localparam int INSTR_W   = 24;
  localparam int OPC_MSB   = 23;
  localparam int OPC_LSB   = 20;
  localparam int OPERAND_W = 20;
  localparam int DC_BIT    = 8;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_PINS    = 4'd1;
  localparam logic [3:0] OP_SEND    = 4'd2;
  localparam logic [3:0] OP_DELAY   = 4'd3;
  localparam logic [3:0] OP_LOOP    = 4'd4;
  localparam logic [3:0] OP_ENDLOOP = 4'd5;
  localparam logic [3:0] OP_HALT    = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_SEND_WAIT, S_DELAY, S_DONE, S_ERR
  } state_t;

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [3:0] opc,
                                                  input logic [OPERAND_W-1:0] operand);
    return {opc, operand};
  endfunction

endpackage

// File: rtl/oled_cmd_sequencer_if.sv
// ROM fetch port and SPI byte handshake between the sequencer (master)
// and its ROM / SPI master (slave).
interface oled_cmd_sequencer_if #(parameter int ADDR_W = 8);
  import oled_seq_pkg::*;

  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [7:0]         spi_data;
  logic               spi_wr;
  logic               spi_done;

  // ROM: rom_data answers rom_addr one cycle later. SPI: spi_wr is a
  // one-cycle strobe with spi_data valid in that cycle; the slave answers
  // with a one-cycle spi_done pulse once the byte has been shifted out.
  modport master (output rom_addr, spi_data, spi_wr, input rom_data, spi_done);
  modport slave  (input rom_addr, spi_data, spi_wr, output rom_data, spi_done);
endinterface

// File: rtl/oled_cmd_sequencer_loop_stack.sv
// LIFO of loop frames {return address, remaining count} with push, pop and
// decrement-top; the caller never pushes when full nor pops when empty.
module oled_seq_loop_stack #(
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 15,
  parameter int LOOP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              dec_i,
  input  logic [ADDR_W-1:0] push_ret_i,
  input  logic [CNT_W-1:0]  push_cnt_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] top_ret_o,
  output logic [CNT_W-1:0]  top_cnt_o
);
  localparam int PTR_W = $clog2(LOOP_DEPTH + 1);
  localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  logic [PTR_W-1:0]  sp_q;
  logic [ADDR_W-1:0] ret_q [LOOP_DEPTH];
  logic [CNT_W-1:0]  cnt_q [LOOP_DEPTH];
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;

  assign push_idx  = IDX_W'(sp_q);
  assign top_idx   = IDX_W'(sp_q - 1'b1);
  assign empty_o   = (sp_q == '0);
  assign full_o    = (sp_q == PTR_W'(LOOP_DEPTH));
  assign top_ret_o = empty_o ? '0 : ret_q[top_idx];
  assign top_cnt_o = empty_o ? '0 : cnt_q[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        ret_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (clr_i) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      ret_q[push_idx] <= push_ret_i;
      cnt_q[push_idx] <= push_cnt_i;
      sp_q            <= sp_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - 1'b1;
    end else if (dec_i && !empty_o) begin
      cnt_q[top_idx] <= top_cnt_o - 1'b1;
    end
  end
endmodule

// File: rtl/oled_cmd_sequencer.sv
// Microcoded SSD1306 power-up sequencer: fetches 24-bit instructions from a
// synchronous ROM, drives panel pins, sends SPI bytes, delays and loops.
// Optional SPI completion watchdog: define OLED_SEQ_SPI_TIMEOUT_EN.
module oled_cmd_sequencer
  import oled_seq_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DELAY_W     = 20,
  parameter int LOOP_DEPTH  = 2,
  parameter int CNT_W       = 15,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  oled_cmd_sequencer_if.master        bus,
  output logic                        oled_vdd,
  output logic                        oled_vbat,
  output logic                        oled_res,
  output logic                        oled_dc,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output state_t                      dbg_state
);
  if (DELAY_W < 1 || DELAY_W > 20) begin : g_bad_delay_w
    $error("DELAY_W must be in 1..20");
  end
  if (CNT_W < 1 || CNT_W > 15) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..15");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [3:0]         pins_q, pins_d;  // {vdd, vbat, res, dc}

  logic [3:0]           opc;
  logic [OPERAND_W-1:0] operand;
  logic [DELAY_W-1:0]   dly_n;
  logic                 adv, spi_wr;
  logic                 stk_clr, stk_push, stk_pop, stk_dec, stk_full, stk_empty;
  logic [ADDR_W-1:0]    top_ret;
  logic [CNT_W-1:0]     top_cnt;

`ifdef OLED_SEQ_SPI_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign opc     = bus.rom_data[OPC_MSB:OPC_LSB];
  assign operand = bus.rom_data[OPERAND_W-1:0];
  assign dly_n   = operand[DELAY_W-1:0];

  oled_seq_loop_stack #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .LOOP_DEPTH(LOOP_DEPTH)
  ) u_stack (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (stk_clr),
    .push_i     (stk_push),
    .pop_i      (stk_pop),
    .dec_i      (stk_dec),
    .push_ret_i (pc_q + 1'b1),
    .push_cnt_i (operand[CNT_W-1:0]),
    .full_o     (stk_full),
    .empty_o    (stk_empty),
    .top_ret_o  (top_ret),
    .top_cnt_o  (top_cnt)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    dly_d    = dly_q;
    pins_d   = pins_q;
    adv      = 1'b0;
    spi_wr   = 1'b0;
    stk_clr  = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_dec  = 1'b0;
`ifdef OLED_SEQ_SPI_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          pc_d    = '0;
          stk_clr = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        case (opc)
          OP_NOP:  adv = 1'b1;
          OP_PINS: begin
            pins_d = operand[3:0];
            adv    = 1'b1;
          end
          OP_SEND: begin
            spi_wr    = 1'b1;
            pins_d[0] = operand[DC_BIT];
            state_d   = S_SEND_WAIT;
`ifdef OLED_SEQ_SPI_TIMEOUT_EN
            tmo_d     = '0;
`endif
          end
          OP_DELAY: begin
            if (dly_n == '0) begin
              adv = 1'b1;
            end else begin
              dly_d   = dly_n - 1'b1;
              state_d = S_DELAY;
            end
          end
          OP_LOOP: begin
            if (stk_full) begin
              state_d = S_ERR;
            end else begin
              stk_push = ~&pc_q;
              adv      = 1'b1;
            end
          end
          OP_ENDLOOP: begin
            if (stk_empty) begin
              state_d = S_ERR;
            end else if (top_cnt != '0) begin
              stk_dec = 1'b1;
              pc_d    = top_ret;
              state_d = S_FETCH;
            end else begin
              stk_pop = 1'b1;
              adv     = 1'b1;
            end
          end
          OP_HALT: state_d = S_DONE;
          default: state_d = S_ERR;
        endcase
      end
      S_SEND_WAIT: begin
        if (bus.spi_done) adv = 1'b1;
`ifdef OLED_SEQ_SPI_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) state_d = S_ERR;
        else tmo_d = tmo_q + 1'b1;
`endif
      end
      S_DELAY: begin
        if (dly_q == '0) adv = 1'b1;
        else dly_d = dly_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Advancing from the last ROM word is a fault rather than a wrap to 0.
    if (adv) begin
      if (&pc_q) begin
        state_d = S_ERR;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      dly_q   <= '0;
      pins_q  <= '0;
`ifdef OLED_SEQ_SPI_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dly_q   <= dly_d;
      pins_q  <= pins_d;
`ifdef OLED_SEQ_SPI_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // dc must already carry the new value while spi_wr strobes.
  assign bus.rom_addr = pc_q;
  assign bus.spi_wr   = spi_wr;
  assign bus.spi_data = spi_wr ? operand[7:0] : 8'h00;
  assign oled_vdd     = pins_q[3];
  assign oled_vbat    = pins_q[2];
  assign oled_res     = pins_q[1];
  assign oled_dc      = spi_wr ? operand[DC_BIT] : pins_q[0];
  assign busy         = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                        (state_q == S_SEND_WAIT) || (state_q == S_DELAY);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign dbg_state    = state_q;
endmodule
